// File: rtl/bus_slave_pkg.sv
// Shared types for the request/response bus slave.
// FSM encoding, default widths and the request bundle.
package bus_slave_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } slv_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/bus_slave_if.sv
// Request/response bus between master agent and slave.
// Master drives requests and rsp_ready; slave drives the rest.
interface bus_slave_if
    import bus_slave_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/slv_regfile.sv
// NUM_REGS x DATA_W register array for the bus slave.
// One synchronous write port, one combinational read port.
module slv_regfile
    import bus_slave_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 16,
    parameter int IW       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_slave_responder.sv
// Slave endpoint: register file behind a request/response bus
// with programmable wait states and out-of-range error responses.
module bus_slave_responder
    import bus_slave_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    bus_slave_if.slave bus
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cap_t;

    slv_state_t        state, state_n;
    logic [7:0]        cnt, cnt_n;
    cap_t              cap, cap_n, req_in, acc;
    logic              rdy_q, rdy_n;
    logic              vld_q, vld_n;
    logic              err_q, err_n;
    logic [DATA_W-1:0] rdata_q, rdata_n, rf_rdata;
    logic              accept, rsp_hs, in_range, access, we;

    assign req_in = {bus.req_write, bus.req_addr, bus.req_wdata};
    assign accept = (state == IDLE) && bus.req_valid && rdy_q;
    assign rsp_hs = (state == RESP) && vld_q && bus.rsp_ready;

    // Zero wait states: the access uses the live request at accept.
    assign acc      = (state == IDLE) ? req_in : cap;
    assign in_range = {1'b0, acc.addr} < LIMIT;
    assign access   = (accept && (WAIT_CYCLES == 0))
                    || ((state == WAIT) && (cnt == '0));
    assign we       = access && acc.write && in_range;

    slv_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IW       (IW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (acc.addr[IW-1:0]),
        .wdata (acc.wdata),
        .raddr (acc.addr[IW-1:0]),
        .rdata (rf_rdata)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        rdy_n   = rdy_q;
        vld_n   = vld_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (accept) begin
                    cap_n = req_in;
                    rdy_n = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = 8'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                rdy_n = 1'b0;
                if (cnt == '0) state_n = RESP;
                else           cnt_n   = cnt - 8'd1;
            end
            RESP: begin
                vld_n = 1'b1;
                if (rsp_hs) begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                    rdy_n   = 1'b1;
                    rdata_n = '0;
                    err_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        // Read data is sampled before the same-edge write lands.
        if (access) begin
            err_n   = !in_range;
            rdata_n = (acc.write || !in_range) ? '0 : rf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cap     <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cap     <= cap_n;
            rdy_q   <= rdy_n;
            vld_q   <= vld_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Scoreboard bench for bus_slave_responder: one DUT with two
// wait states, one with zero wait states, shared clock/reset.
module tb_bus_slave_responder;
    import bus_slave_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;

    exp_t        sb2[$];
    exp_t        sb0[$];
    logic [31:0] m2[16];
    logic [31:0] m0[16];

    bus_slave_if #(.ADDR_W(8), .DATA_W(32)) b2 ();
    bus_slave_if #(.ADDR_W(8), .DATA_W(32)) b0 ();

    bus_slave_responder #(
        .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    bus_slave_responder #(
        .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t apply2(req_t r);
        exp_t e;
        e.rdata = '0;
        e.err   = 1'b0;
        if (r.addr >= 8'd16) e.err = 1'b1;
        else if (r.write)    m2[r.addr[3:0]] = r.wdata;
        else                 e.rdata = m2[r.addr[3:0]];
        return e;
    endfunction

    function automatic exp_t apply0(req_t r);
        exp_t e;
        e.rdata = '0;
        e.err   = 1'b0;
        if (r.addr >= 8'd16) e.err = 1'b1;
        else if (r.write)    m0[r.addr[3:0]] = r.wdata;
        else                 e.rdata = m0[r.addr[3:0]];
        return e;
    endfunction

    function automatic req_t mk(logic w, logic [7:0] a, logic [31:0] d);
        req_t r;
        r.write = w;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic issue(input req_t r, output int acc);
        sb2.push_back(apply2(r));
        b2.req_write = r.write;
        b2.req_addr  = r.addr;
        b2.req_wdata = r.wdata;
        b2.req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b2.req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        b2.req_valid = 1'b0;
        if (acc < 0) begin
            nvec++;
            nbad++;
            $display("FAIL accept_timeout: req_ready=0, required 1");
        end
    endtask

    task automatic collect(input string name, input int acc);
        exp_t e;
        bit   got;
        got = 1'b0;
        b2.rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b2.rsp_valid) begin
                got = 1'b1;
                if (sb2.size() != 0) begin
                    e = sb2.pop_front();
                end else begin
                    e.rdata = 'x;
                    e.err   = 1'bx;
                end
                nvec++;
                if (b2.rsp_rdata !== e.rdata || b2.rsp_err !== e.err) begin
                    nbad++;
                    $display("FAIL %s: rdata=%h err=%b, required rdata=%h err=%b",
                             name, b2.rsp_rdata, b2.rsp_err, e.rdata, e.err);
                end
                if (acc >= 0) begin
                    nvec++;
                    if (cyc != acc + 3) begin
                        nbad++;
                        $display("FAIL %s_latency: rsp at edge %0d, required %0d",
                                 name, cyc, acc + 3);
                    end
                end
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!got) begin
            nvec++;
            nbad++;
            $display("FAIL %s_timeout: rsp_valid=0, required 1", name);
        end
    endtask

    task automatic test_reset();
        int acc;
        rst = 1'b0;
        b2.req_valid = 1'b0; b2.req_write = 1'b0;
        b2.req_addr = '0; b2.req_wdata = '0; b2.rsp_ready = 1'b1;
        b0.req_valid = 1'b0; b0.req_write = 1'b0;
        b0.req_addr = '0; b0.req_wdata = '0; b0.rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m2[i] = '0;
            m0[i] = '0;
        end
        repeat (50) @(negedge clk);
        nvec++;
        if (b2.req_ready !== 1'b0) begin
            nbad++;
            $display("FAIL rst_req_ready: %b, required 0", b2.req_ready);
        end
        nvec++;
        if (b2.rsp_valid !== 1'b0) begin
            nbad++;
            $display("FAIL rst_rsp_valid: %b, required 0", b2.rsp_valid);
        end
        nvec++;
        if (b2.rsp_rdata !== 32'h0 || b2.rsp_err !== 1'b0) begin
            nbad++;
            $display("FAIL rst_rsp_data: rdata=%h err=%b, required 0 0",
                     b2.rsp_rdata, b2.rsp_err);
        end
        nvec++;
        if ({b0.req_ready, b0.rsp_valid, b0.rsp_err} !== 3'b000
            || b0.rsp_rdata !== 32'h0) begin
            nbad++;
            $display("FAIL rst_dut0_outputs: nonzero, required all 0");
        end
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (b2.req_ready !== 1'b1 || b0.req_ready !== 1'b1) begin
            nbad++;
            $display("FAIL rst_release_ready: %b/%b, required 1/1",
                     b2.req_ready, b0.req_ready);
        end
        issue(mk(1'b0, 8'd3, '0), acc);
        collect("rst_read3", acc);
    endtask

    task automatic test_write_read();
        int acc;
        issue(mk(1'b1, 8'd5, 32'hDEADBEEF), acc);
        collect("wr5", acc);
        issue(mk(1'b0, 8'd5, '0), acc);
        collect("rd5", acc);
        issue(mk(1'b1, 8'd15, 32'h0F0F1234), acc);
        collect("wr15", acc);
        issue(mk(1'b1, 8'd5, 32'h00C0FFEE), acc);
        collect("wr5b", acc);
        issue(mk(1'b0, 8'd15, '0), acc);
        collect("rd15", acc);
        issue(mk(1'b0, 8'd5, '0), acc);
        collect("rd5b", acc);
    endtask

    task automatic test_out_of_range();
        int acc;
        issue(mk(1'b1, 8'd16, 32'h12345678), acc);
        collect("oor_wr16", acc);
        issue(mk(1'b0, 8'd0, '0), acc);
        collect("oor_rd0", acc);
        issue(mk(1'b0, 8'd16, '0), acc);
        collect("oor_rd16", acc);
        issue(mk(1'b0, 8'd255, '0), acc);
        collect("oor_rd255", acc);
    endtask

    task automatic test_backpressure();
        int          acc;
        bit          got;
        exp_t        e;
        logic [31:0] snap;
        logic        snap_err;
        b2.rsp_ready = 1'b0;
        issue(mk(1'b0, 8'd5, '0), acc);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b2.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        e = sb2.pop_front();
        nvec++;
        if (!got || b2.rsp_rdata !== e.rdata || b2.rsp_err !== e.err) begin
            nbad++;
            $display("FAIL bp_rsp: valid=%b rdata=%h err=%b, required 1 %h %b",
                     b2.rsp_valid, b2.rsp_rdata, b2.rsp_err, e.rdata, e.err);
        end
        snap     = b2.rsp_rdata;
        snap_err = b2.rsp_err;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nvec++;
            if (b2.rsp_valid !== 1'b1 || b2.rsp_rdata !== snap
                || b2.rsp_err !== snap_err || b2.req_ready !== 1'b0) begin
                nbad++;
                $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b, required 1 %h 0",
                         i, b2.rsp_valid, b2.rsp_rdata, b2.req_ready, snap);
            end
        end
        b2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if (b2.rsp_valid !== 1'b0 || b2.req_ready !== 1'b1) begin
            nbad++;
            $display("FAIL bp_release: valid=%b ready=%b, required 0 1",
                     b2.rsp_valid, b2.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int  acc;
        bit  seen;
        acc = -1;
        b2.req_write = 1'b1;
        b2.req_addr  = 8'd2;
        b2.req_wdata = 32'hA5A5A5A5;
        b2.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b2.req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        b2.req_valid = 1'b0;
        nvec++;
        if (acc < 0) begin
            nbad++;
            $display("FAIL mid_accept: req_ready=0, required 1");
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (b2.rsp_valid) seen = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m2[i] = '0;
            m0[i] = '0;
        end
        sb2.delete();
        repeat (8) begin
            @(negedge clk);
            if (b2.rsp_valid) seen = 1'b1;
        end
        nvec++;
        if (seen) begin
            nbad++;
            $display("FAIL mid_no_rsp: rsp_valid=1, required 0");
        end
        issue(mk(1'b0, 8'd2, '0), acc);
        collect("mid_rd2", acc);
    endtask

    task automatic test_back_to_back();
        req_t rq[8];
        exp_t e;
        int   k, nacc, nrsp, last_acc;
        bit   acc_now;
        for (int i = 0; i < 4; i++) begin
            rq[i]     = mk(1'b1, 8'(i + 1), 32'hC0DE0000 + 32'(i * 17));
            rq[i + 4] = mk(1'b0, 8'(i + 1), '0);
        end
        k = 0;
        nacc = 0;
        nrsp = 0;
        last_acc = -100;
        b0.rsp_ready = 1'b1;
        b0.req_write = rq[0].write;
        b0.req_addr  = rq[0].addr;
        b0.req_wdata = rq[0].wdata;
        b0.req_valid = 1'b1;
        for (int i = 0; i < 60 && nrsp < 8; i++) begin
            @(negedge clk);
            acc_now = 1'b0;
            if (b0.rsp_valid) begin
                e = sb0.pop_front();
                nvec++;
                if (b0.rsp_rdata !== e.rdata || b0.rsp_err !== e.err) begin
                    nbad++;
                    $display("FAIL b2b_rsp%0d: rdata=%h err=%b, required %h %b",
                             nrsp, b0.rsp_rdata, b0.rsp_err, e.rdata, e.err);
                end
                nvec++;
                if (cyc != last_acc + 1) begin
                    nbad++;
                    $display("FAIL b2b_lat%0d: rsp at %0d, required %0d",
                             nrsp, cyc, last_acc + 1);
                end
                nrsp++;
            end
            if (b0.req_valid && b0.req_ready) acc_now = 1'b1;
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (nacc > 0) begin
                    nvec++;
                    if (cyc - last_acc != 3) begin
                        nbad++;
                        $display("FAIL b2b_gap%0d: %0d edges, required 3",
                                 nacc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                sb0.push_back(apply0(rq[k]));
                k++;
                nacc++;
                if (k < 8) begin
                    b0.req_write = rq[k].write;
                    b0.req_addr  = rq[k].addr;
                    b0.req_wdata = rq[k].wdata;
                end else begin
                    b0.req_valid = 1'b0;
                end
            end
        end
        b0.req_valid = 1'b0;
        nvec++;
        if (nrsp != 8) begin
            nbad++;
            $display("FAIL b2b_count: %0d responses, required 8", nrsp);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
